// File: rtl/synth_pkg.sv
// Shared constants and types for the synth register-write path and its SPI front end.
package synth_pkg;

    localparam int SPI_WORD_WIDTH        = 16;
    localparam int REGISTER_NUMBER_WIDTH = 16;
    localparam int BIT_COUNT_WIDTH       = $clog2(SPI_WORD_WIDTH);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ADDRESS,
        DATA
    } SpiState_t;

endpackage

// File: rtl/spi_register_controller_if.sv
// SPI pins plus the synth register-write port of spi_register_controller, grouped as one bundle.
interface spi_register_controller_if;
    import synth_pkg::*;

    logic                             spi_clock;
    logic                             spi_chip_select_n;
    logic                             spi_mosi;
    logic                             spi_miso;
    logic [REGISTER_NUMBER_WIDTH-1:0] register_number;
    logic [SPI_WORD_WIDTH-1:0]        register_value;
    logic                             register_write_enable;
    logic                             frame_error;
    logic                             busy;

    // register_write_enable is a one-cycle strobe; number/value are valid only while it is high
    modport master (
        input  spi_clock, spi_chip_select_n, spi_mosi,
        output spi_miso, register_number, register_value, register_write_enable,
        output frame_error, busy
    );

    modport slave (
        output spi_clock, spi_chip_select_n, spi_mosi,
        input  spi_miso, register_number, register_value, register_write_enable,
        input  frame_error, busy
    );

endinterface

// File: rtl/spi_input_synchronizer.sv
// Brings one asynchronous SPI pin into the i_Clock domain and optionally flags its edges.
module spi_input_synchronizer #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VALUE = 1'b0,
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_Async};
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_Level = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_DETECT) begin : g_edges
            logic history_q;
            logic history_d;

            always_comb begin
                history_d = o_Level;
            end

            always_ff @(posedge i_Clock) begin
                if (i_Reset) begin
                    history_q <= RESET_VALUE;
                end else begin
                    history_q <= history_d;
                end
            end

            assign o_Rise = o_Level & ~history_q;
            assign o_Fall = ~o_Level & history_q;
        end else begin : g_level_only
            assign o_Rise = 1'b0;
            assign o_Fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_register_controller.sv
// Mode-0 SPI slave: one register-number word then data words, each data word becomes a
// single-cycle write on the synth register port with the number auto-incrementing.
module spi_register_controller
    import synth_pkg::*;
#(
    parameter int                               SYNC_STAGES       = 2,
    parameter logic [REGISTER_NUMBER_WIDTH-1:0] ADDRESS_INCREMENT = REGISTER_NUMBER_WIDTH'(1)
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset,
    input  logic                             i_SpiClock,
    input  logic                             i_SpiChipSelect_n,
    input  logic                             i_SpiMosi,
    output logic                             o_SpiMiso,
    output logic [REGISTER_NUMBER_WIDTH-1:0] o_RegisterNumber,
    output logic [SPI_WORD_WIDTH-1:0]        o_RegisterValue,
    output logic                             o_RegisterWriteEnable,
    output logic                             o_FrameError,
    output logic                             o_Busy
);

    localparam int                         SETTLE_WIDTH = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_WIDTH-1:0]    SETTLE_DONE  = SETTLE_WIDTH'(SYNC_STAGES);
    localparam logic [BIT_COUNT_WIDTH-1:0] LAST_BIT     = BIT_COUNT_WIDTH'(SPI_WORD_WIDTH - 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0), .EDGE_DETECT(1'b1)) u_sclk_sync (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SpiClock),
        .o_Level(sclk_level_unused), .o_Rise(sclk_rise), .o_Fall(sclk_fall)
    );

    // CS_n powers up as "deselected" so o_Busy is low out of reset
    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1), .EDGE_DETECT(1'b1)) u_cs_sync (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SpiChipSelect_n),
        .o_Level(cs_level), .o_Rise(cs_rise), .o_Fall(cs_fall)
    );

    spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0), .EDGE_DETECT(1'b0)) u_mosi_sync (
        .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SpiMosi),
        .o_Level(mosi_level), .o_Rise(mosi_rise_unused), .o_Fall(mosi_fall_unused)
    );

    SpiState_t                        state_q, state_d;
    logic [SETTLE_WIDTH-1:0]          settle_q, settle_d;
    logic [BIT_COUNT_WIDTH-1:0]       bit_count_q, bit_count_d;
    logic [SPI_WORD_WIDTH-1:0]        shift_q, shift_d;
    logic [SPI_WORD_WIDTH-1:0]        echo_q, echo_d;
    logic [REGISTER_NUMBER_WIDTH-1:0] address_q, address_d;
    logic                             write_pending_q, write_pending_d;
    logic [REGISTER_NUMBER_WIDTH-1:0] reg_number_q, reg_number_d;
    logic [SPI_WORD_WIDTH-1:0]        reg_value_q, reg_value_d;
    logic                             write_enable_q, write_enable_d;
    logic                             frame_error_q, frame_error_d;

    always_comb begin
        state_d         = state_q;
        settle_d        = settle_q;
        bit_count_d     = bit_count_q;
        shift_d         = shift_q;
        echo_d          = echo_q;
        address_d       = address_q;
        write_pending_d = 1'b0;
        reg_number_d    = reg_number_q;
        reg_value_d     = reg_value_q;
        write_enable_d  = 1'b0;
        frame_error_d   = 1'b0;

        // A data word finished last cycle: publish it, then step the register number
        if (write_pending_q) begin
            reg_number_d   = address_q;
            reg_value_d    = shift_q;
            write_enable_d = 1'b1;
            address_d      = address_q + ADDRESS_INCREMENT;
        end

        case (state_q)
            WAIT_IDLE: begin
                // Let the CS_n chain flush its reset value before trusting a high level
                if (settle_q != SETTLE_DONE) begin
                    settle_d = settle_q + 1'b1;
                end else if (cs_level) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ADDRESS;
                    bit_count_d = '0;
                    echo_d      = '0;
                end
            end
            ADDRESS, DATA: begin
                if (sclk_rise) begin
                    shift_d     = {shift_q[SPI_WORD_WIDTH-2:0], mosi_level};
                    bit_count_d = bit_count_q + 1'b1;
                    if (bit_count_q == LAST_BIT) begin
                        echo_d = shift_d;
                        if (state_q == ADDRESS) begin
                            address_d = shift_d;
                            state_d   = DATA;
                        end else begin
                            write_pending_d = 1'b1;
                        end
                    end
                end else if (sclk_fall && (bit_count_q != '0)) begin
                    // The fall that ends a word keeps the freshly loaded bit 15 on MISO
                    echo_d = {echo_q[SPI_WORD_WIDTH-2:0], 1'b0};
                end
                if (cs_rise) begin
                    frame_error_d = (bit_count_d != '0);
                    bit_count_d   = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q         <= WAIT_IDLE;
            settle_q        <= '0;
            bit_count_q     <= '0;
            shift_q         <= '0;
            echo_q          <= '0;
            address_q       <= '0;
            write_pending_q <= 1'b0;
            reg_number_q    <= '0;
            reg_value_q     <= '0;
            write_enable_q  <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            settle_q        <= settle_d;
            bit_count_q     <= bit_count_d;
            shift_q         <= shift_d;
            echo_q          <= echo_d;
            address_q       <= address_d;
            write_pending_q <= write_pending_d;
            reg_number_q    <= reg_number_d;
            reg_value_q     <= reg_value_d;
            write_enable_q  <= write_enable_d;
            frame_error_q   <= frame_error_d;
        end
    end

    assign o_SpiMiso             = echo_q[SPI_WORD_WIDTH-1];
    assign o_RegisterNumber      = reg_number_q;
    assign o_RegisterValue       = reg_value_q;
    assign o_RegisterWriteEnable = write_enable_q;
    assign o_FrameError          = frame_error_q;
    assign o_Busy                = ~cs_level;

endmodule

// File: doc/spi_register_controller.md
# spi_register_controller

Serial front end that configures the synth from an external MCU. It is a mode-0 SPI slave that oversamples SCLK, CS_n and MOSI in the system clock domain and deserialises frames of one 16-bit register number followed by one or more 16-bit values. Each value becomes a single-cycle write on the synth register-write port (`i_RegisterNumber` / `i_RegisterValue` / `i_RegisterWriteEnable`). The register number auto-increments between values.

## Interface

Clock is `i_Clock`. Reset is `i_Reset`, synchronous and active-high.

Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages on each SPI input before edge detection. Minimum 2.
- `ADDRESS_INCREMENT`, default 1: added to the register number after each written value.

Ports:
- `i_Clock`  in  1: system clock.
- `i_Reset`  in  1: synchronous, active-high.
- `i_SpiClock`  in  1: SCLK, asynchronous, idle low.
- `i_SpiChipSelect_n`  in  1: CS_n, asynchronous, active-low.
- `i_SpiMosi`  in  1: MOSI, MSB first.
- `o_SpiMiso`  out  1: echo of the previously received 16-bit word, MSB first.
- `o_RegisterNumber`  out  16: write address to the synth.
- `o_RegisterValue`  out  16: write data to the synth.
- `o_RegisterWriteEnable`  out  1: single-cycle write strobe.
- `o_FrameError`  out  1: single-cycle pulse when CS_n rises mid-word.
- `o_Busy`  out  1: high while CS_n is low (synchronised).

## Operation

- SPI mode 0:
  - MOSI is sampled on the detected SCLK rising edge.
  - MISO is updated on the detected SCLK falling edge.
- Each input passes through `SYNC_STAGES` flip-flops. One further history register produces rise/fall detection.
- A 4-bit bit counter and a 16-bit shift register assemble each word. The counter resets to 0 on CS_n fall.
- FSM states:
  - `WAIT_IDLE`: entered on reset. Moves to `IDLE` only once synchronised CS_n reads high. This prevents joining a frame mid-stream.
  - `IDLE`: CS_n fall moves to `ADDRESS`. SCLK edges are ignored.
  - `ADDRESS`: after the 16th rising edge, load the shift register into the address register and move to `DATA`.
  - `DATA`: after each 16th rising edge:
    - drive `o_RegisterNumber` = address register and `o_RegisterValue` = shift register;
    - pulse `o_RegisterWriteEnable` for one cycle;
    - then address register += `ADDRESS_INCREMENT`, 16-bit wrap (0xFFFF + 1 = 0x0000).
    - Stay in `DATA`.
  - In any of `ADDRESS` / `DATA`, CS_n rise returns to `IDLE`.
- Frame error: a CS_n rise with bit counter ≠ 0 pulses `o_FrameError`. The partial word is discarded and no write occurs.
- A CS_n rise after the address word but before any data word is legal: no write, no error.
- MISO echo:
  - On completion of each word, that word is copied into the echo register.
  - In the next word, the echo register shifts out MSB first.
  - Bit 15 is presented when CS_n falls and after the 16th rising edge of the previous word.
  - MISO is 0 in the first word of a frame.
- Simultaneous events: if an SCLK rise and a CS_n rise are detected in the same cycle, the SCLK rise is processed first, then the CS_n rise. A word completing on that edge is therefore written.
- SCLK edges while CS_n is high are ignored in every state.

## Timing

- Reset values:
  - all outputs 0;
  - FSM in `WAIT_IDLE`;
  - address, shift and echo registers 0;
  - bit counter 0.
- `i_Reset` mid-frame aborts without a write or error pulse, then waits for CS_n high.
- SCLK frequency ≤ `i_Clock`/8. SCLK high and low phases must each be ≥ 3 `i_Clock` periods.
- Latency: the write strobe is asserted `SYNC_STAGES` + 2 `i_Clock` cycles after the physical 16th SCLK rise.
- `o_RegisterNumber` and `o_RegisterValue` are registered. They hold their values until the next write.
- `o_RegisterWriteEnable` is never high on two consecutive cycles. Minimum spacing is 16 SCLK periods.
- `o_FrameError` is asserted one cycle after the detected CS_n rise.
- `o_Busy` tracks synchronised CS_n with no extra delay.

## Structure

- Shared package `synth_pkg`:
  - `SPI_WORD_WIDTH` = 16;
  - `SpiState_t` enum (`WAIT_IDLE`, `IDLE`, `ADDRESS`, `DATA`);
  - `REGISTER_NUMBER_WIDTH` = 16, also used by `synth`.
- Sub-module `spi_input_synchronizer`:
  - per-bit `SYNC_STAGES` chain plus history register;
  - outputs level, rise and fall;
  - instantiated for SCLK and CS_n;
  - MOSI uses a level-only instance.
- The top level holds the FSM, bit counter, shift/address/echo registers and output registers.
- `o_Register*` connect directly to `synth` `i_Register*`.

## Test plan

- Single write: frame 0x1100, 0x0001 → exactly one strobe with number 0x1100, value 0x0001; `o_FrameError` stays 0.
- Burst: frame 0x2103, then 0x8000, 0x4000, 0x0123 → strobes at 0x2103, 0x2104, 0x2105 with those values; MISO during word 3 reads 0x8000.
- Wrap: address 0xFFFF, then two values 0xAAAA, 0x5555 → writes to 0xFFFF then 0x0000.
- Aborted word: address 0x1101, then 7 data bits, then CS_n high → one `o_FrameError` pulse, no strobe; the next full frame writes normally.
- Reset mid-frame: assert `i_Reset` after 20 bits with CS_n held low; resume clocking → no strobe until CS_n goes high and a new frame 0x1102, 0x0007 writes 0x0007 to 0x1102.
- Minimum-rate stress: SCLK = `i_Clock`/8 with a 16-value burst → 16 strobes at consecutive addresses, with strobe latency `SYNC_STAGES` + 2 cycles after each 16th SCLK rise.
